// File: rtl/itcm_arbiter.sv
// Single-port ITCM arbiter: fetch vs load/store reads with starvation guard.
// Optional program-loader path (ld_* ports, DRAIN/LOAD states) enabled by ITCM_LOADER_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module itcm_arbiter #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [DATA_WIDTH-1:0] ls_rdata,
`ifdef ITCM_LOADER_EN
  input  logic                  ld_mode,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_ready,
`endif
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // state | meaning
  // RUN   | fetch and load/store reads arbitrated, one grant per cycle
  // DRAIN | grants blocked while the last read response returns
  // LOAD  | program loader owns the memory port
  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_e;

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              own_if_q, own_if_d;
  logic              own_ls_q, own_ls_d;
  logic              grant_ok;
  logic              ls_wins;
  logic              cnt_hold;

`ifdef ITCM_LOADER_EN
  logic in_load;

  assign in_load  = (state_q == LOAD);
  assign ld_ready = in_load;
  // ld_mode blocks grants in the very cycle it rises so DRAIN only sees one response
  assign grant_ok = (state_q == RUN) && !ld_mode;
  assign cnt_hold = in_load;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (ld_mode) state_d = DRAIN;
      DRAIN:   state_d = ld_mode ? LOAD : RUN;
      LOAD:    if (!ld_mode) state_d = RUN;
      default: state_d = RUN;
    endcase
  end
`else
  assign grant_ok = (state_q == RUN);
  assign cnt_hold = 1'b0;
  assign state_d  = RUN;
`endif

  assign ls_wins = ls_req && (!if_req || (wait_cnt_q >= WAIT_MAX));
  assign if_gnt  = grant_ok && if_req && !ls_wins;
  assign ls_gnt  = grant_ok && ls_wins;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end else if (ls_gnt) begin
      mem_en   = 1'b1;
      mem_addr = ls_addr;
    end
`ifdef ITCM_LOADER_EN
    else if (in_load) begin
      mem_en    = ld_we;
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end
`endif
  end

  always_comb begin
    wait_cnt_d = '0;
    if (!cnt_hold && ls_req && !ls_gnt)
      wait_cnt_d = (wait_cnt_q >= WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 1'b1;
  end

  assign own_if_d = if_gnt;
  assign own_ls_d = ls_gnt;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      own_if_q   <= 1'b0;
      own_ls_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      own_if_q   <= own_if_d;
      own_ls_q   <= own_ls_d;
    end
  end

  assign if_rvalid = own_if_q;
  assign ls_rvalid = own_ls_q;
  assign if_rdata  = own_if_q ? mem_rdata : '0;
  assign ls_rdata  = own_ls_q ? mem_rdata : '0;

endmodule

// File: doc/itcm_arbiter.md
ITCM_ARBITER -- requirements
Module: itcm_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default `ADDR_WIDTH (32), byte address width of all address ports.
REQ-002 Parameter DATA_WIDTH, default `DATA_WIDTH (32), width of all data ports.
REQ-003 Parameter MAX_WAIT, default 4, consecutive denied cycles after which the load/store requester wins priority.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-high reset (asserted = 1), sampled on rising clk edge.
REQ-006 if_req / if_addr  input  1 / ADDR_WIDTH  instruction-fetch read request and address.
REQ-007 if_gnt / if_rvalid / if_rdata  output  1 / 1 / DATA_WIDTH  fetch grant, response valid, read data.
REQ-008 ls_req / ls_addr  input  1 / ADDR_WIDTH  load/store-side read request into instruction memory.
REQ-009 ls_gnt / ls_rvalid / ls_rdata  output  1 / 1 / DATA_WIDTH  load/store grant, response valid, read data.
REQ-010 ld_mode / ld_we / ld_addr / ld_wdata  input  1 / 1 / ADDR_WIDTH / DATA_WIDTH  program-loader mode request and write port (loader builds only).
REQ-011 ld_ready  output  1  loader owns the memory (loader builds only).
REQ-012 mem_en / mem_we / mem_addr / mem_wdata  output  1 / 1 / ADDR_WIDTH / DATA_WIDTH  ITCM port controls.
REQ-013 mem_rdata  input  DATA_WIDTH  ITCM read data, valid one cycle after mem_en && !mem_we.

Function
REQ-014 FSM states: RUN, DRAIN, LOAD; one memory access (read or write) per cycle maximum.
REQ-015 In RUN, at most one of if_gnt/ls_gnt is high per cycle; both are combinational from the current request inputs, counter and state.
REQ-016 Priority: fetch wins when both request, unless wait_cnt >= MAX_WAIT, in which case ls wins.
REQ-017 wait_cnt increments (saturating at MAX_WAIT) each cycle ls_req=1 && ls_gnt=0; clears when ls_gnt=1 or ls_req=0.
REQ-018 On a grant: mem_en=1, mem_we=0, mem_addr = granted requester's address, same cycle.
REQ-019 Response latency exactly 1 cycle: registered owner tag drives if_rvalid or ls_rvalid the cycle after grant; only owner's rdata = mem_rdata, other rdata = 0.
REQ-020 No request: mem_en=0, mem_addr=0, both gnt 0.
REQ-021 RUN -> DRAIN when ld_mode=1; no grants issued in that cycle or in DRAIN.
REQ-022 DRAIN -> LOAD after one cycle (outstanding read response delivered during DRAIN).
REQ-023 In LOAD: ld_ready=1; mem_en=mem_we=ld_we, mem_addr=ld_addr, mem_wdata=ld_wdata; if_gnt=ls_gnt=0; wait_cnt held at 0.
REQ-024 LOAD -> RUN when ld_mode=0; grants resume the following cycle; ld_we ignored outside LOAD.
REQ-025 ld_mode dropped while in DRAIN -> return to RUN next cycle, no write issued.

Reset
REQ-026 While rst_n=1: state=RUN, wait_cnt=0, owner tag cleared; next cycle all gnt, rvalid, rdata, mem_* and ld_ready are 0.
REQ-027 Reset mid-operation discards any pending response; no rvalid is produced for a grant issued in the reset cycle.

Configuration
REQ-028 Macro ITCM_LOADER_EN: when defined, ld_* ports, ld_ready, DRAIN and LOAD states exist as above.
REQ-029 When ITCM_LOADER_EN undefined: ld_* ports and ld_ready absent, FSM fixed in RUN, mem_we and mem_wdata tied to 0.

Verification
REQ-030 Fetch only: if_req=1, if_addr=0x10 -> if_gnt=1, mem_addr=0x10 same cycle; next cycle if_rvalid=1, if_rdata=mem_rdata.
REQ-031 Contention: if_req=ls_req=1 continuously, MAX_WAIT=4 -> fetch granted cycles 0-3, ls granted cycle 4, pattern repeats every 5 cycles.
REQ-032 Back-to-back: fetch grant cycle 0, ls grant cycle 1 -> if_rvalid cycle 1 only, ls_rvalid cycle 2 only, non-owner rdata=0.
REQ-033 Loader: ld_mode=1 with fetch outstanding -> response still delivered, ld_ready=1 two cycles later; ld_we=1, ld_addr=0x40, ld_wdata=0xDEADBEEF -> mem_we=1 with those values; fetch read of 0x40 after ld_mode=0 returns 0xDEADBEEF.
REQ-034 Reset during grant cycle -> no rvalid next cycle, all outputs 0, wait_cnt=0.
REQ-035 Build without ITCM_LOADER_EN -> mem_we constantly 0 across REQ-030..032 stimulus.
